// File: rtl/fifo_ctrl_if.sv
// Producer/consumer and RAM-side signal bundle for fifo_ctrl.
// Build with FIFO_ALMOST_EN to add almost_full/almost_empty.
interface fifo_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] w_add;
  logic              w_en;
  logic [ADDR_W-1:0] r_add;
  logic              r_en;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
`ifdef FIFO_ALMOST_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  modport master (
    output push,
    output pop,
    input  w_add,
    input  w_en,
    input  r_add,
    input  r_en,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  underflow
`ifdef FIFO_ALMOST_EN
    ,
    input  almost_full,
    input  almost_empty
`endif
  );

  modport slave (
    input  push,
    input  pop,
    output w_add,
    output w_en,
    output r_add,
    output r_en,
    output full,
    output empty,
    output count,
    output overflow,
    output underflow
`ifdef FIFO_ALMOST_EN
    ,
    output almost_full,
    output almost_empty
`endif
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a single-clock FIFO over a dual-port RAM.
// Define FIFO_ALMOST_EN to add almost_full/almost_empty thresholds.
module fifo_ctrl #(
  parameter int ADDR_W   = 4
`ifdef FIFO_ALMOST_EN
  ,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;

  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;

  // Flags come from the occupancy counter, so wr_ptr == rd_ptr is never
  // ambiguous between full and empty.
  always_comb begin
    full   = (count_q == DEPTH_C);
    empty  = (count_q == '0);
    wr_acc = bus.push && !full;
    rd_acc = bus.pop && !empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = bus.push && full;
    unf_d    = bus.pop && empty;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case (1'b1)
      wr_acc && !rd_acc: count_d = count_q + CNT_ONE;
      rd_acc && !wr_acc: count_d = count_q - CNT_ONE;
      default:           count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.w_en      = wr_acc;
  assign bus.w_add     = wr_ptr_q;
  assign bus.r_en      = rd_acc;
  assign bus.r_add     = rd_ptr_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

`ifdef FIFO_ALMOST_EN
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LEVEL);

  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
`endif

  a_count_bound: assert property (
    @(posedge clk) disable iff (reset)
    count_q <= DEPTH_C
  );

  a_ptr_gap: assert property (
    @(posedge clk) disable iff (reset)
    (wr_ptr_q - rd_ptr_q) == count_q[ADDR_W-1:0]
  );

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer and flag controller for the single-clock FIFO built around the team's dual-port RAM.
- Accepts push/pop requests.
- Gates them against full/empty.
- Drives RAM write and read address/enable.
- Tracks occupancy and reports overflow/underflow.
- Sits between the producer/consumer handshake and the RAM instance; holds no data itself.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_W (16 entries by default)
AF_LEVEL, 12, almost_full threshold (count >= AF_LEVEL); used only with FIFO_ALMOST_EN
AE_LEVEL, 4, almost_empty threshold (count <= AE_LEVEL); used only with FIFO_ALMOST_EN

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
push  input  1  producer write request, sampled each cycle
pop  input  1  consumer read request, sampled each cycle
w_add  output  ADDR_W  RAM write address (current write pointer)
w_en  output  1  RAM write enable
r_add  output  ADDR_W  RAM read address (current read pointer)
r_en  output  1  RAM read enable
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  registered pulse: push rejected last cycle
underflow  output  1  registered pulse: pop rejected last cycle
almost_full  output  1  present only with FIFO_ALMOST_EN
almost_empty  output  1  present only with FIFO_ALMOST_EN

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk. Reset has priority over push/pop in the same cycle.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - overflow = 0, underflow = 0.
  - Derived outputs: empty = 1, full = 0, w_en = 0, r_en = 0, w_add = 0, r_add = 0.
- Internal state: wr_ptr, rd_ptr (ADDR_W bits each), count (ADDR_W+1 bits), overflow/underflow flops.
- Accept terms, combinational from current state:
  - wr_acc = push && !full
  - rd_acc = pop && !empty
- Outputs driven combinationally, same cycle as the request:
  - w_en = wr_acc; w_add = wr_ptr.
  - r_en = rd_acc; r_add = rd_ptr.
  - The RAM captures the write on the same edge that advances wr_ptr. Read data appears per RAM read latency (1 cycle); the controller does not register data.
- Pointer update on the clock edge:
  - wr_ptr += 1 if wr_acc; rd_ptr += 1 if rd_acc.
  - Pointers wrap modulo DEPTH (DEPTH-1 -> 0) with no extra logic.
- Count update:
  - +1 if wr_acc only; -1 if rd_acc only; unchanged if both or neither.
  - count never exceeds DEPTH and never goes below 0.
- Full/empty: flags are decoded from count, not from pointer comparison.
- Simultaneous push and pop:
  - Empty: pop rejected, push accepted → count 0 -> 1, underflow pulses.
  - Full: push rejected, pop accepted → count DEPTH -> DEPTH-1, overflow pulses. No write-through when full.
  - Otherwise both accepted, count unchanged, both pointers advance.
- Error flags:
  - overflow <= push && full; underflow <= pop && empty.
  - Each is high for exactly one cycle per rejected request.
  - Rejected requests do not move pointers or count.
- Reset mid-operation: all contents are logically discarded (pointers and count to 0); the RAM is not cleared.

Optional Feature:
FIFO_ALMOST_EN
- Defined:
  - Ports almost_full and almost_empty exist.
  - almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL); both combinational from count.
  - Reset values: almost_full = 0, almost_empty = 1.
- Not defined: both ports and all threshold logic are absent; AF_LEVEL/AE_LEVEL are unused.

Test Plan:
- Reset, idle 3 cycles → empty=1, full=0, count=0, w_en=0, r_en=0, w_add=0, r_add=0.
- 16 consecutive pushes from reset → w_add steps 0..15 with w_en=1; after the 16th, full=1, count=16, wr_ptr wrapped to 0. A 17th push → w_en=0, overflow=1 for one cycle, count stays 16.
- From full, 16 pops → r_add 0..15, r_en=1, empty=1 after the last. A further pop → r_en=0, underflow=1 one cycle.
- count=5, push+pop held 20 cycles → count stays 5; both pointers advance 20 (mod 16); no error flags.
- Push+pop with empty=1 → count 1, underflow=1. Push+pop with full=1 → count 15, overflow=1.
- count=7, assert reset with push=1 → next cycle count=0, empty=1, pointers 0, no overflow.
- With FIFO_ALMOST_EN: pushes from 0 → almost_empty drops when count reaches 5; almost_full rises when count reaches 12.
